// File: rtl/id_exe_reg.sv
// -----------------------------------------------------------------------------
// id_exe_reg
// Pipeline register between the ARM decode (ID) and execute (EXE) stages.
// Every field from decode is captured on the rising clock edge. Two pipeline
// controls act on the slot: freeze holds everything (whole-pipeline stall) and
// flush replaces the slot with an all-zero, invalid entry (taken branch in EXE).
// Edge priority: rst > freeze > flush > load.
//
// Optional feature macro: ID_EXE_PERF_EN
//   When defined, adds perf_clr (input) and three saturating CNT_W-bit event
//   counters: perf_flush_cnt, perf_freeze_cnt, perf_bubble_cnt.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   freeze, flush       pipeline hold / bubble-insert controls
//   *_in                decoded control vector, operands, immediates, PC, tags,
//                       NZCV status from ID
//   wb_en .. status     registered copies of the *_in fields, same widths
//   valid               slot holds a non-flushed instruction
//   bubble              slot is valid but its control vector is all zero
//   perf_*              event counters and clear (ID_EXE_PERF_EN only)
// -----------------------------------------------------------------------------
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        status_in,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [3:0]        exe_cmd,
    output logic              b,
    output logic              s,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic [3:0]        status,
`ifdef ID_EXE_PERF_EN
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_freeze_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt,
`endif
    output logic              valid,
    output logic              bubble
);

    // A load whose control vector is entirely zero is a bubble: the slot is
    // occupied (valid) but the instruction has no architectural effect, e.g.
    // a hazard stall insert or a condition-failed instruction from decode.
    logic load_bubble_s;

    // Detect an all-zero control vector on the incoming instruction.
    always_comb begin
        load_bubble_s = ~(wb_en_in | mem_r_en_in | mem_w_en_in |
                          b_in | s_in | (|exe_cmd_in));
    end

    // Slot register: reset clears, freeze holds, flush zeroes, otherwise load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            exe_cmd       <= 4'd0;
            b             <= 1'b0;
            s             <= 1'b0;
            pc            <= {DATA_W{1'b0}};
            val_rn        <= {DATA_W{1'b0}};
            val_rm        <= {DATA_W{1'b0}};
            imm           <= 1'b0;
            shift_operand <= 12'd0;
            signed_imm_24 <= 24'd0;
            dest          <= 4'd0;
            src1          <= 4'd0;
            src2          <= 4'd0;
            status        <= 4'd0;
            valid         <= 1'b0;
            bubble        <= 1'b0;
        end else if (!freeze) begin
            // Freeze wins over flush: the frozen EXE stage re-presents its
            // flush once freeze drops, so nothing is lost by ignoring it here.
            if (flush) begin
                wb_en         <= 1'b0;
                mem_r_en      <= 1'b0;
                mem_w_en      <= 1'b0;
                exe_cmd       <= 4'd0;
                b             <= 1'b0;
                s             <= 1'b0;
                pc            <= {DATA_W{1'b0}};
                val_rn        <= {DATA_W{1'b0}};
                val_rm        <= {DATA_W{1'b0}};
                imm           <= 1'b0;
                shift_operand <= 12'd0;
                signed_imm_24 <= 24'd0;
                dest          <= 4'd0;
                src1          <= 4'd0;
                src2          <= 4'd0;
                status        <= 4'd0;
                valid         <= 1'b0;
                bubble        <= 1'b0;
            end else begin
                wb_en         <= wb_en_in;
                mem_r_en      <= mem_r_en_in;
                mem_w_en      <= mem_w_en_in;
                exe_cmd       <= exe_cmd_in;
                b             <= b_in;
                s             <= s_in;
                pc            <= pc_in;
                val_rn        <= val_rn_in;
                val_rm        <= val_rm_in;
                imm           <= imm_in;
                shift_operand <= shift_operand_in;
                signed_imm_24 <= signed_imm_24_in;
                dest          <= dest_in;
                src1          <= src1_in;
                src2          <= src2_in;
                status        <= status_in;
                valid         <= 1'b1;
                bubble        <= load_bubble_s;
            end
        end
    end

`ifdef ID_EXE_PERF_EN
    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : (v + {{(CNT_W-1){1'b0}}, 1'b1});
    endfunction

    // Event counters; perf_clr overrides any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_flush_cnt  <= {CNT_W{1'b0}};
            perf_freeze_cnt <= {CNT_W{1'b0}};
            perf_bubble_cnt <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            perf_flush_cnt  <= {CNT_W{1'b0}};
            perf_freeze_cnt <= {CNT_W{1'b0}};
            perf_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            if (flush && !freeze) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
            if (freeze) begin
                perf_freeze_cnt <= sat_inc(perf_freeze_cnt);
            end
            // Only a real load (no freeze, no flush) can insert a bubble.
            if (!freeze && !flush && load_bubble_s) begin
                perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_exe_reg
// Self-checking bench for id_exe_reg: directed scenarios followed by random
// stimulus, every output compared against a record-level model of the slot.
// -----------------------------------------------------------------------------
module tb_id_exe_reg;

    typedef struct {
        logic        wb, mr, mw;
        logic [3:0]  cmd;
        logic        br, st;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0]  dest, s1, s2, nzcv;
        logic        valid, bubble;
    } slot_t;

    logic clk = 1'b0;
    logic rst, freeze, flush;
    slot_t in_s, exp_s;
    int n_cmp = 0;
    int n_bad = 0;

    logic        wb_en, mem_r_en, mem_w_en, b, s, imm, valid, bubble;
    logic [3:0]  exe_cmd, dest, src1, src2, status;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

`ifdef ID_EXE_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_flush_cnt, perf_freeze_cnt, perf_bubble_cnt;
    logic [1:0]  sm_flush_cnt, sm_freeze_cnt, sm_bubble_cnt;
    logic        sm_wb, sm_mr, sm_mw, sm_b, sm_s, sm_imm, sm_valid, sm_bubble;
    logic [3:0]  sm_cmd, sm_dest, sm_src1, sm_src2, sm_status;
    logic [31:0] sm_pc, sm_rn, sm_rm;
    logic [11:0] sm_sh;
    logic [23:0] sm_si;
    int pf, pz, pb, qz;
`endif

    always #5 clk = ~clk;

    id_exe_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .wb_en_in(in_s.wb), .mem_r_en_in(in_s.mr), .mem_w_en_in(in_s.mw),
        .exe_cmd_in(in_s.cmd), .b_in(in_s.br), .s_in(in_s.st),
        .pc_in(in_s.pc), .val_rn_in(in_s.rn), .val_rm_in(in_s.rm),
        .imm_in(in_s.imm), .shift_operand_in(in_s.sh),
        .signed_imm_24_in(in_s.si), .dest_in(in_s.dest), .src1_in(in_s.s1),
        .src2_in(in_s.s2), .status_in(in_s.nzcv),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .exe_cmd(exe_cmd), .b(b), .s(s), .pc(pc), .val_rn(val_rn),
        .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .src1(src1),
        .src2(src2), .status(status),
`ifdef ID_EXE_PERF_EN
        .perf_clr(perf_clr), .perf_flush_cnt(perf_flush_cnt),
        .perf_freeze_cnt(perf_freeze_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .valid(valid), .bubble(bubble)
    );

`ifdef ID_EXE_PERF_EN
    // Narrow-counter instance, used only to observe saturation.
    id_exe_reg #(.DATA_W(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .wb_en_in(in_s.wb), .mem_r_en_in(in_s.mr), .mem_w_en_in(in_s.mw),
        .exe_cmd_in(in_s.cmd), .b_in(in_s.br), .s_in(in_s.st),
        .pc_in(in_s.pc), .val_rn_in(in_s.rn), .val_rm_in(in_s.rm),
        .imm_in(in_s.imm), .shift_operand_in(in_s.sh),
        .signed_imm_24_in(in_s.si), .dest_in(in_s.dest), .src1_in(in_s.s1),
        .src2_in(in_s.s2), .status_in(in_s.nzcv),
        .wb_en(sm_wb), .mem_r_en(sm_mr), .mem_w_en(sm_mw),
        .exe_cmd(sm_cmd), .b(sm_b), .s(sm_s), .pc(sm_pc), .val_rn(sm_rn),
        .val_rm(sm_rm), .imm(sm_imm), .shift_operand(sm_sh),
        .signed_imm_24(sm_si), .dest(sm_dest), .src1(sm_src1),
        .src2(sm_src2), .status(sm_status),
        .perf_clr(perf_clr), .perf_flush_cnt(sm_flush_cnt),
        .perf_freeze_cnt(sm_freeze_cnt), .perf_bubble_cnt(sm_bubble_cnt),
        .valid(sm_valid), .bubble(sm_bubble)
    );
`endif

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic slot_t zero_slot();
        slot_t z;
        z.wb = 1'b0; z.mr = 1'b0; z.mw = 1'b0; z.cmd = 4'd0; z.br = 1'b0;
        z.st = 1'b0; z.pc = 32'd0; z.rn = 32'd0; z.rm = 32'd0; z.imm = 1'b0;
        z.sh = 12'd0; z.si = 24'd0; z.dest = 4'd0; z.s1 = 4'd0; z.s2 = 4'd0;
        z.nzcv = 4'd0; z.valid = 1'b0; z.bubble = 1'b0;
        return z;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic logic is_nop(input slot_t x);
        return (x.wb + x.mr + x.mw + x.br + x.st + x.cmd) == 0;
    endfunction

    // What one clock edge does to the slot, from the stated rules.
    task automatic model_edge();
        if (rst) begin
            exp_s = zero_slot();
        end else if (freeze) begin
            exp_s = exp_s;
        end else if (flush) begin
            exp_s = zero_slot();
        end else begin
            exp_s = in_s;
            exp_s.valid = 1'b1;
            exp_s.bubble = is_nop(in_s);
        end
`ifdef ID_EXE_PERF_EN
        if (rst || perf_clr) begin
            pf = 0; pz = 0; pb = 0; qz = 0;
        end else begin
            if (flush && !freeze) pf = sat(pf, 65535);
            if (freeze) begin
                pz = sat(pz, 65535);
                qz = sat(qz, 3);
            end
            if (!freeze && !flush && is_nop(in_s)) pb = sat(pb, 65535);
        end
`endif
    endtask

    task automatic compare_all();
        check_eq("ctrl", {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd},
                 {exp_s.wb, exp_s.mr, exp_s.mw, exp_s.br, exp_s.st, exp_s.cmd});
        check_eq("pc", pc, exp_s.pc);
        check_eq("val_rn", val_rn, exp_s.rn);
        check_eq("val_rm", val_rm, exp_s.rm);
        check_eq("imm_fields", {imm, shift_operand, signed_imm_24},
                 {exp_s.imm, exp_s.sh, exp_s.si});
        check_eq("tags", {dest, src1, src2, status},
                 {exp_s.dest, exp_s.s1, exp_s.s2, exp_s.nzcv});
        check_eq("valid", valid, exp_s.valid);
        check_eq("bubble", bubble, exp_s.bubble);
`ifdef ID_EXE_PERF_EN
        check_eq("perf_flush", perf_flush_cnt, pf);
        check_eq("perf_freeze", perf_freeze_cnt, pz);
        check_eq("perf_bubble", perf_bubble_cnt, pb);
        check_eq("perf_freeze_sat", sm_freeze_cnt, qz);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_inputs(input int nop_pct);
        in_s.wb = 1'($urandom); in_s.mr = 1'($urandom); in_s.mw = 1'($urandom);
        in_s.cmd = 4'($urandom); in_s.br = 1'($urandom); in_s.st = 1'($urandom);
        if ($urandom_range(0, 99) < nop_pct) begin
            in_s.wb = 1'b0; in_s.mr = 1'b0; in_s.mw = 1'b0;
            in_s.cmd = 4'd0; in_s.br = 1'b0; in_s.st = 1'b0;
        end
        in_s.pc = $urandom; in_s.rn = $urandom; in_s.rm = $urandom;
        in_s.imm = 1'($urandom); in_s.sh = 12'($urandom); in_s.si = 24'($urandom);
        in_s.dest = 4'($urandom); in_s.s1 = 4'($urandom); in_s.s2 = 4'($urandom);
        in_s.nzcv = 4'($urandom);
    endtask

    // Reset asserted between edges must clear outputs without any clock.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        exp_s = zero_slot();
`ifdef ID_EXE_PERF_EN
        pf = 0; pz = 0; pb = 0; qz = 0;
`endif
        compare_all();
        step();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        in_s = zero_slot();
        exp_s = zero_slot();
`ifdef ID_EXE_PERF_EN
        perf_clr = 1'b0; pf = 0; pz = 0; pb = 0; qz = 0;
`endif
        step();
        #2;
        rst = 1'b0;

        // Reset in the middle of operation, then the next edge loads.
        rand_inputs(0);
        step();
        check_eq("loaded_valid", valid, 1'b1);
        async_reset_check();
        step();

        // Directed load.
        in_s = zero_slot();
        in_s.wb = 1'b1; in_s.cmd = 4'b0010; in_s.rn = 32'h0000_0005; in_s.dest = 4'd3;
        step();
        check_eq("load_rn", val_rn, 32'h0000_0005);
        check_eq("load_bubble", bubble, 1'b0);

        // Freeze holds pc 0x10 for 3 cycles while pc_in moves to 0x14.
        in_s.pc = 32'h10;
        step();
        freeze = 1'b1;
        in_s.pc = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("freeze_pc", pc, 32'h10);
        end
        freeze = 1'b0;
        step();
        check_eq("release_pc", pc, 32'h14);

        // Flush with a store pending, then flush+freeze holds the bubble.
        in_s.mw = 1'b1;
        flush = 1'b1;
        step();
        check_eq("flush_mw", mem_w_en, 1'b0);
        check_eq("flush_valid", valid, 1'b0);
        freeze = 1'b1;
        step();
        freeze = 1'b0;
        step();
        flush = 1'b0;
        in_s = zero_slot();
        in_s.wb = 1'b1; in_s.rn = 32'hABCD_0001;
        freeze = 1'b1;
        step();
        freeze = 1'b0; flush = 1'b1;
        in_s.mw = 1'b1;
        step();
        flush = 1'b0;
        in_s = zero_slot();
        in_s.wb = 1'b1; in_s.rn = 32'h1234_5678;
        step();
        flush = 1'b1; freeze = 1'b1;
        step();
        check_eq("flush_freeze_hold", val_rn, 32'h1234_5678);
        flush = 1'b0; freeze = 1'b0;

        // Bubble load keeps data.
        in_s = zero_slot();
        in_s.rm = 32'hDEAD_BEEF;
        step();
        check_eq("bubble_flag", bubble, 1'b1);
        check_eq("bubble_rm", val_rm, 32'hDEAD_BEEF);

`ifdef ID_EXE_PERF_EN
        // Counter scenario: 2 flushes, 5 freezes, 1 bubble load.
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        in_s.wb = 1'b1;
        flush = 1'b1;
        step(); step();
        flush = 1'b0; freeze = 1'b1;
        for (int i = 0; i < 5; i++) step();
        freeze = 1'b0;
        in_s = zero_slot();
        step();
        check_eq("cnt_flush_2", perf_flush_cnt, 16'd2);
        check_eq("cnt_freeze_5", perf_freeze_cnt, 16'd5);
        check_eq("cnt_bubble_1", perf_bubble_cnt, 16'd1);
        check_eq("cnt_freeze_sat3", sm_freeze_cnt, 2'd3);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check_eq("cnt_clr", {perf_flush_cnt, perf_freeze_cnt, perf_bubble_cnt}, 48'd0);
`endif

        // Random traffic with freeze, flush, bubbles and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(25);
            freeze = ($urandom_range(0, 9) < 2);
            flush  = ($urandom_range(0, 9) < 2);
`ifdef ID_EXE_PERF_EN
            perf_clr = ($urandom_range(0, 49) == 0);
`endif
            if ($urandom_range(0, 59) == 0) begin
                async_reset_check();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
